// File: rtl/aww_types_pkg.sv
// ============================================================================
// aww_types_pkg : shared types for the branch predictor (kinds, BTB entry).
// Rev 1.0
// ============================================================================
`default_nettype none

package aww_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BP_BRANCH = 2'd0,
    BP_JUMP   = 2'd1,
    BP_CALL   = 2'd2,
    BP_RETURN = 2'd3
  } bp_kind_t;

  // Tag and counter fields are sized for the widest legal configuration;
  // narrower builds keep the unused upper bits at zero.
  localparam int unsigned BP_TAG_MAX_W = 30;
  localparam int unsigned BP_CNT_MAX_W = 8;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    bp_kind_t                kind;
    word_t                   target;
    logic [BP_CNT_MAX_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [BP_CNT_MAX_W-1:0] BP_CNT_WT(input int unsigned w);
    return BP_CNT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/return_stack.sv
// ============================================================================
// return_stack : circular LIFO of return addresses; a push when full
// overwrites the oldest entry, a pop when empty is ignored.  Rev 1.0
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot; the power-of-two depth makes it wrap freely.
  assign top_idx = ptr_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != (PTR_W+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : BTB + saturating-counter direction predictor; optional
// return-address stack enabled by defining BP_RAS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_predictor
  import aww_types_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic     CLK,
  input  logic     nRST,
  input  word_t    lookup_pc,
  input  logic     fetch_adv,
  output logic     pred_hit,
  output logic     pred_taken,
  output word_t    pred_target,
  input  logic     upd_en,
  input  word_t    upd_pc,
  input  bp_kind_t upd_kind,
  input  logic     upd_taken,
  input  word_t    upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [BP_CNT_MAX_W-1:0] CNT_MAX = BP_CNT_MAX_W'((1 << CNT_W) - 1);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]        l_idx, u_idx;
  logic [BP_TAG_MAX_W-1:0] l_tag, u_tag;
  btb_entry_t              l_entry, u_entry, upd_entry_d;
  logic                    u_hit, upd_we;
  logic                    ras_use;
  word_t                   ras_top;
  logic                    unused_bits;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign l_tag = BP_TAG_MAX_W'(lookup_pc[31:IDX_W+2]);
  assign u_tag = BP_TAG_MAX_W'(upd_pc[31:IDX_W+2]);
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], fetch_adv};

  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = lookup_pc + 32'd4;
    l_entry     = btb_q[l_idx];
    if (l_entry.valid && l_entry.tag == l_tag) begin
      pred_hit = 1'b1;
      unique case (l_entry.kind)
        BP_BRANCH: if (l_entry.cnt[CNT_W-1]) begin
          pred_taken  = 1'b1;
          pred_target = l_entry.target;
        end
        BP_RETURN: begin
          pred_taken  = 1'b1;
          pred_target = ras_use ? ras_top : l_entry.target;
        end
        default: begin
          pred_taken  = 1'b1;
          pred_target = l_entry.target;
        end
      endcase
    end
  end

  always_comb begin
    u_entry     = btb_q[u_idx];
    upd_entry_d = u_entry;
    upd_we      = 1'b0;
    u_hit       = u_entry.valid && (u_entry.tag == u_tag);
    if (upd_en) begin
      if (u_hit) begin
        upd_we           = 1'b1;
        upd_entry_d.kind = upd_kind;
        if (upd_taken) begin
          upd_entry_d.target = upd_target;
          if (u_entry.cnt != CNT_MAX) upd_entry_d.cnt = u_entry.cnt + 1'b1;
        end else if (u_entry.cnt != '0) begin
          upd_entry_d.cnt = u_entry.cnt - 1'b1;
        end
      end else if (upd_taken || upd_kind != BP_BRANCH) begin
        // Not-taken branches that miss are not worth a BTB slot.
        upd_we             = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = u_tag;
        upd_entry_d.kind   = upd_kind;
        upd_entry_d.target = upd_target;
        upd_entry_d.cnt    = BP_CNT_WT(CNT_W);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (upd_we) begin
      btb_q[u_idx] <= upd_entry_d;
    end
  end

`ifdef BP_RAS_EN
  logic ras_push, ras_pop, ras_empty;

  assign ras_push = fetch_adv && pred_hit && (l_entry.kind == BP_CALL);
  assign ras_pop  = fetch_adv && pred_hit && (l_entry.kind == BP_RETURN);
  assign ras_use  = !ras_empty;

  return_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (lookup_pc + 32'd4),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );
`else
  assign ras_use = 1'b0;
  assign ras_top = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor : directed checks of lookup, training, aliasing, RAS
// (when BP_RAS_EN is defined) and asynchronous reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;
  import aww_types_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  word_t    lookup_pc;
  logic     fetch_adv;
  logic     pred_hit, pred_taken;
  word_t    pred_target;
  logic     upd_en;
  word_t    upd_pc;
  bp_kind_t upd_kind;
  logic     upd_taken;
  word_t    upd_target;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(
    .ENTRIES   (16),
    .CNT_W     (2),
    .RAS_DEPTH (4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .lookup_pc   (lookup_pc),
    .fetch_adv   (fetch_adv),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_kind    (upd_kind),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input string tag, input word_t pc, input logic eh,
                      input logic et, input word_t etgt);
    lookup_pc = pc;
    #1;
    chk({tag, ".hit"},    32'(pred_hit),   32'(eh));
    chk({tag, ".taken"},  32'(pred_taken), 32'(et));
    chk({tag, ".target"}, pred_target,     etgt);
  endtask

  task automatic upd(input word_t pc, input bp_kind_t k, input logic t, input word_t tgt);
    upd_en = 1'b1; upd_pc = pc; upd_kind = k; upd_taken = t; upd_target = tgt;
    tick();
    upd_en = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; lookup_pc = 32'h40; fetch_adv = 1'b0;
    upd_en = 1'b0; upd_pc = '0; upd_kind = BP_BRANCH; upd_taken = 1'b0; upd_target = '0;
    #12;
    look("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    nRST = 1'b1;
    tick();

    // Allocate weakly taken, then train down to strongly not-taken.
    upd(32'h100, BP_BRANCH, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, BP_BRANCH, 1'b0, 32'h0);
    upd(32'h100, BP_BRANCH, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // 0 -> 3 saturated; then 2 (taken), then 1 (not taken).
    for (int i = 0; i < 4; i++) upd(32'h100, BP_BRANCH, 1'b1, 32'h200);
    upd(32'h100, BP_BRANCH, 1'b0, 32'h0);
    look("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, BP_BRANCH, 1'b0, 32'h0);
    look("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // 0x140 aliases 0x100 at index 0.
    upd(32'h140, BP_JUMP, 1'b1, 32'h500);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h500);
    upd(32'h300, BP_BRANCH, 1'b0, 32'h0);
    look("nt_miss", 32'h300, 1'b0, 1'b0, 32'h304);
    look("nt_keep", 32'h140, 1'b1, 1'b1, 32'h500);

    upd(32'h20, BP_RETURN, 1'b1, 32'h80);
`ifdef BP_RAS_EN
    look("ret_empty", 32'h20, 1'b1, 1'b1, 32'h80);
    lookup_pc = 32'h400; upd(32'h400, BP_CALL, 1'b1, 32'h1000);
    fetch_adv = 1'b1;
    look("call", 32'h400, 1'b1, 1'b1, 32'h1000);
    tick();
    fetch_adv = 1'b0;
    look("ret_top", 32'h20, 1'b1, 1'b1, 32'h404);
    lookup_pc = 32'h400; fetch_adv = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    lookup_pc = 32'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("pop%0d.target", i), pred_target, (i < 4) ? 32'h404 : 32'h80);
      tick();
    end
    fetch_adv = 1'b0;
    look("ret_fallback", 32'h20, 1'b1, 1'b1, 32'h80);
`else
    look("ret_btb", 32'h20, 1'b1, 1'b1, 32'h80);
`endif

    // Same-cycle update and lookup: old view now, new view after the edge.
    upd(32'h100, BP_BRANCH, 1'b1, 32'h200);
    upd_en = 1'b1; upd_pc = 32'h100; upd_kind = BP_BRANCH; upd_taken = 1'b0; upd_target = '0;
    look("same_pre", 32'h100, 1'b1, 1'b1, 32'h200);
    tick();
    upd_en = 1'b0;
    look("same_post", 32'h100, 1'b1, 1'b0, 32'h104);

    // Asynchronous reset mid-stream, with an update pending.
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    #2;
    nRST = 1'b0;
    look("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    look("rst_hold", 32'h140, 1'b0, 1'b0, 32'h144);
    upd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
